// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ifetch_pkg;
    localparam int XLEN        = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_MAX_OUT = 2;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] dat;
        logic [XLEN-1:0] pc;
    } inst_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read from storage flops.
// Latency: push visible at the head on the cycle after the push.
// Backpressure: push accepted when not full or when popping in the same cycle.
module ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch: drives PC hold/redirect, issues imem requests, queues tagged responses for decode.
// Latency: grant to inst_valid is response cycle + 1 (same cycle when IFETCH_BYPASS_EN is defined).
// Backpressure: no request while queue plus outstanding would exceed DEPTH or outstanding hits MAX_OUT.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);
    localparam int QCW = $clog2(DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUT + 1);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [QCW-1:0]  q_count;
    logic [TCW-1:0]  out_count;
    logic [TCW-1:0]  out_nxt;
    logic            grant;
    logic            drop;
    logic            byp;
    logic            q_empty;
    logic            q_push;
    logic [XLEN-1:0] tag_pc;
    inst_t           q_in;
    inst_t           q_head;

    assign imem_addr = pc_cur;
    assign grant     = imem_req & imem_gnt;
    assign out_nxt   = out_count + TCW'(grant) - TCW'(imem_rvalid);
    // Anything returning during a redirect or while draining belongs to the old path.
    assign drop      = redirect_valid || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = (out_nxt != '0) ? DRAIN : RUN;
        end else begin
            case (state)
                BOOT:    state_nxt = RUN;
                RUN:     state_nxt = RUN;
                DRAIN:   state_nxt = (out_nxt == '0) ? RUN : DRAIN;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        pc_load  = 1'b0;
        pc_in    = pc_cur;
        if (!rst) begin
            imem_req = (state == RUN) && !redirect_valid
                    && (int'(q_count) + int'(out_count) < DEPTH)
                    && (int'(out_count) < MAX_OUT);
            if (redirect_valid) begin
                pc_load = 1'b1;
                pc_in   = redirect_pc;
            end else begin
                pc_load = !(imem_req && imem_gnt);
            end
        end
    end

    ifetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (grant),
        .push_dat (imem_addr),
        .pop      (imem_rvalid),
        .pop_dat  (tag_pc),
        .count    (out_count)
    );

`ifdef IFETCH_BYPASS_EN
    assign byp = q_empty && imem_rvalid && !drop && inst_ready;
`else
    assign byp = 1'b0;
`endif

    assign q_in   = '{dat: imem_rdata, pc: tag_pc};
    assign q_push = imem_rvalid && !drop && !byp;

    ifetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_inst_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (q_push),
        .push_dat (q_in),
        .pop      (inst_ready),
        .pop_dat  (q_head),
        .count    (q_count)
    );

    assign q_empty    = (q_count == '0);
    assign inst_valid = !q_empty || byp;
    assign inst_data  = byp ? imem_rdata : q_head.dat;
    assign inst_pc    = byp ? tag_pc     : q_head.pc;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomised bench for ifetch_ctrl: PC register and in-order memory modelled here, decode stream checked per redirect epoch.
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_cur;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    ifetch_ctrl #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_load        (pc_load),
        .pc_in          (pc_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // PC register on the producer side, reset by the same rst.
    always @(posedge clk) begin
        if (rst)          pc_cur <= 32'h1000;
        else if (pc_load) pc_cur <= pc_in;
        else              pc_cur <= pc_cur + 32'd4;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return NOP ^ (a << 8);
    endfunction

    // Stimulus knobs and memory model.
    int          gnt_pct = 100;
    int          rv_pct  = 100;
    int          rdy_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          redir_req = 1'b0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] pend_addr [$];
    int          pend_rdy  [$];

    // Reference model: decode sees consecutive PCs from the epoch start.
    int          cyc       = 0;
    int          outst     = 0;
    int          held      = 0;
    int          drop_cnt  = 0;
    bit          boot      = 1'b1;
    bit          rst_prev  = 1'b0;
    logic [31:0] exp_pc    = 32'h1000;
    int          grant_cnt = 0;
    logic [31:0] acc_pc [$];

    task automatic drive();
        imem_gnt       = (int'($urandom_range(99)) < gnt_pct);
        inst_ready     = (int'($urandom_range(99)) < rdy_pct);
        redirect_valid = redir_req;
        redirect_pc    = redir_tgt;
        redir_req      = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if (!rst && pend_addr.size() > 0 && pend_rdy[0] <= cyc
            && int'($urandom_range(99)) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        #3;
    endtask

    always @(negedge clk) begin
        bit exp_req;
        bit gr;
        bit drp;
        bit byp;
        bit vld;
        bit hs;
        if (rst) begin
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_pc_load", 32'(pc_load), 32'd0);
            if (rst_prev) begin
                chk("rst_inst_valid", 32'(inst_valid), 32'd0);
                chk("rst_inst_data", inst_data, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
            end
            outst = 0; held = 0; drop_cnt = 0; boot = 1'b1; exp_pc = 32'h1000;
            pend_addr.delete();
            pend_rdy.delete();
        end else begin
            exp_req = !boot && drop_cnt == 0 && !redirect_valid
                   && (held + outst < DEPTH) && (outst < MAX_OUT);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, pc_cur);
            gr  = exp_req && imem_gnt;
            drp = redirect_valid || drop_cnt > 0;
            if (redirect_valid) begin
                chk("pc_load_redir", 32'(pc_load), 32'd1);
                chk("pc_in_redir", pc_in, redirect_pc);
            end else if (gr) begin
                chk("pc_load_grant", 32'(pc_load), 32'd0);
            end else begin
                chk("pc_load_hold", 32'(pc_load), 32'd1);
                chk("pc_in_hold", pc_in, pc_cur);
            end
`ifdef IFETCH_BYPASS_EN
            byp = held == 0 && imem_rvalid && !drp && inst_ready;
`else
            byp = 1'b0;
`endif
            vld = held > 0 || byp;
            chk("inst_valid", 32'(inst_valid), 32'(vld));
            if (vld) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_data", inst_data, word_of(exp_pc));
            end
            hs = vld && inst_ready;
            if (hs) begin
                acc_pc.push_back(inst_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (gr) begin
                pend_addr.push_back(pc_cur);
                pend_rdy.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                grant_cnt++;
            end
            outst = outst + int'(gr) - int'(imem_rvalid);
            if (redirect_valid) begin
                held     = 0;
                drop_cnt = outst;
                exp_pc   = redirect_pc;
            end else begin
                if (imem_rvalid && drop_cnt > 0) drop_cnt--;
                else if (imem_rvalid && !byp)    held++;
                if (hs && !byp) held--;
            end
            boot = 1'b0;
        end
        rst_prev = rst;
        cyc++;
    end

    initial begin
        logic [31:0] base;
        int          gc0;

        rst = 1'b1;
        repeat (3) tick();

        // Boot cycle, first grant, first response.
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        #3;
        chk("boot_imem_req", 32'(imem_req), 32'd0);
        chk("boot_pc_load", 32'(pc_load), 32'd1);
        chk("boot_pc_in", pc_in, 32'h1000);
        tick();
        chk("r1_imem_req", 32'(imem_req), 32'd1);
        chk("r1_imem_addr", imem_addr, 32'h1000);
        chk("r1_pc_load", 32'(pc_load), 32'd0);
        tick();
`ifdef IFETCH_BYPASS_EN
        chk("r2_inst_valid_bypass", 32'(inst_valid), 32'd1);
`else
        chk("r2_inst_valid", 32'(inst_valid), 32'd0);
`endif

        // Grant withheld for three cycles at 0x1008.
        gnt_pct = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
`ifdef IFETCH_BYPASS_EN
                chk("r3_inst_pc", inst_pc, 32'h1004);
`else
                chk("r3_inst_pc", inst_pc, 32'h1000);
`endif
            end
            chk("stall_imem_req", 32'(imem_req), 32'd1);
            chk("stall_imem_addr", imem_addr, 32'h1008);
            chk("stall_pc_load", 32'(pc_load), 32'd1);
            chk("stall_pc_in", pc_in, 32'h1008);
        end
        gnt_pct = 100;
        for (int i = 0; i < 40 && acc_pc.size() < 3; i++) tick();
        chk("first3_done", 32'(acc_pc.size() >= 3), 32'd1);
        if (acc_pc.size() >= 3) begin
            chk("first_pc0", acc_pc[0], 32'h1000);
            chk("first_pc1", acc_pc[1], 32'h1004);
            chk("first_pc2", acc_pc[2], 32'h1008);
        end

        // Backpressure: exactly DEPTH grants into an empty pipe, then requests stop.
        gnt_pct = 0;
        repeat (8) tick();
        base = pc_cur;
        gc0  = grant_cnt;
        rdy_pct = 0;
        gnt_pct = 100;
        repeat (12) tick();
        chk("bp_grants", 32'(grant_cnt - gc0), 32'd4);
        chk("bp_imem_req", 32'(imem_req), 32'd0);
        acc_pc.delete();
        rdy_pct = 100;
        for (int i = 0; i < 40 && acc_pc.size() < 4; i++) tick();
        chk("bp_drain_done", 32'(acc_pc.size() >= 4), 32'd1);
        if (acc_pc.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("bp_order", acc_pc[k], base + 32'(4 * k));
        end
        for (int i = 0; i < 20 && grant_cnt <= gc0 + 4; i++) tick();
        chk("bp_resume", 32'(grant_cnt > gc0 + 4), 32'd1);

        // Redirect with two responses outstanding.
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (outst == 2) break;
            drive();
            #3;
        end
        chk("redir_outst2", 32'(outst), 32'd2);
        redir_req = 1'b1;
        redir_tgt = 32'h2000;
        drive();
        #3;
        chk("redir_pc_load", 32'(pc_load), 32'd1);
        chk("redir_pc_in", pc_in, 32'h2000);
        #2;
        acc_pc.delete();
        tick();
        chk("drain_imem_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 40 && acc_pc.size() < 1; i++) tick();
        chk("redir_first_done", 32'(acc_pc.size() >= 1), 32'd1);
        if (acc_pc.size() >= 1) chk("redir_first_pc", acc_pc[0], 32'h2000);

        // Redirect while the memory grants at 0x1010.
        rst = 1'b1;
        lat_min = 1;
        lat_max = 1;
        repeat (2) tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        #3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (pc_cur == 32'h1010) break;
            drive();
            #3;
        end
        chk("coinc_pc", pc_cur, 32'h1010);
        redir_req = 1'b1;
        redir_tgt = 32'h2000;
        drive();
        #3;
        chk("coinc_pc_in", pc_in, 32'h2000);
        chk("coinc_pc_load", 32'(pc_load), 32'd1);
        #2;
        acc_pc.delete();
        for (int i = 0; i < 40 && acc_pc.size() < 1; i++) tick();
        chk("coinc_first_done", 32'(acc_pc.size() >= 1), 32'd1);
        if (acc_pc.size() >= 1) chk("coinc_first_pc", acc_pc[0], 32'h2000);

        // Random traffic with redirects and one mid-run reset.
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (i % 200 == 0) begin
                gnt_pct = int'($urandom_range(100, 20));
                rv_pct  = int'($urandom_range(100, 20));
                rdy_pct = int'($urandom_range(100, 10));
            end
            if ($urandom_range(49) == 0) begin
                redir_req = 1'b1;
                redir_tgt = {$urandom_range(32'hFFFF, 0) , 16'h0} | {20'h0, 10'($urandom_range(1023)), 2'b00};
            end
            if (i == 1500) rst = 1'b1;
            if (i == 1503) rst = 1'b0;
            drive();
            #3;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
